sobel_window_fetch: RTL

- Raster-scan sequencer that feeds the Sobel stage with 3x3 pixel windows read from the 512x384 frame BRAM.
- Drives the current centre coordinate to coordinate_to_address and consumes its nine neighbour addresses.
- Issues the nine BRAM reads one per cycle and assembles the returned pixels into a window.
- Zeroes out-of-frame neighbours itself, so a non-black pixel (0,0) never leaks into the border.
- Hands each window downstream over a valid/ready handshake.

---
 rtl/sobel_window_fetch.sv | 94 +++++++++
 1 files changed

// File: rtl/sobel_window_fetch.sv
// sobel_window_fetch: raster-scan 3x3 window fetcher that zeroes border pixels
// and hands each window downstream over a valid/ready handshake.
module sobel_window_fetch #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 384,
    parameter int ADDR_W = 18,
    parameter int PIX_W  = 8,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [10:0]           x_out,
    output logic [10:0]           y_out,
    input  logic [9*ADDR_W-1:0]   addr_in,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [PIX_W-1:0]      mem_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [9*PIX_W-1:0]    win_data,
    output logic [10:0]           win_x,
    output logic [10:0]           win_y
);
    localparam int CW = $clog2((RD_LAT > 9 ? RD_LAT : 9) + 1);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_PRESENT} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [15:0] pad_mask;
    logic pad, hs, last, x_last;
    logic [RD_LAT-1:0] pv, pp;
    logic [3:0] pk [RD_LAT];
    assign x_last = x_out == 11'(IMG_W - 1);
    assign last = x_last && y_out == 11'(IMG_H - 1);
    assign hs = state == S_PRESENT && win_ready;
    // bit k set when neighbour k of the current centre falls outside the frame
    assign pad_mask = {7'd0, (y_out == 11'd0 ? 9'b000000111 : 9'd0)
                           | (y_out == 11'(IMG_H - 1) ? 9'b111000000 : 9'd0)
                           | (x_out == 11'd0 ? 9'b001001001 : 9'd0)
                           | (x_last ? 9'b100100100 : 9'd0)};
    assign pad = pad_mask[cnt[3:0]];
    assign mem_en = state == S_ISSUE && !pad;
    assign mem_addr = mem_en ? addr_in[cnt*ADDR_W +: ADDR_W] : '0;
    assign win_valid = state == S_PRESENT;
    assign busy = state != S_IDLE;
    assign win_x = x_out;
    assign win_y = y_out;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start && !done ? S_ISSUE : S_IDLE;
            S_ISSUE: state_nx = cnt == CW'(8) ? S_WAIT : S_ISSUE;
            S_WAIT:  state_nx = cnt == CW'(RD_LAT - 1) ? S_PRESENT : S_WAIT;
            default: state_nx = hs ? (last ? S_IDLE : S_ISSUE) : S_PRESENT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt <= '0;
            x_out <= '0;
            y_out <= '0;
            done <= 1'b0;
            win_data <= '0;
            pv <= '0;
            pp <= '0;
            for (int i = 0; i < RD_LAT; i++) pk[i] <= '0;
        end else begin
            state <= state_nx;
            cnt <= state_nx != state ? '0 : cnt + 1'b1;
            done <= hs && last;
            if ((state == S_IDLE && state_nx == S_ISSUE) || (hs && last)) begin
                x_out <= '0;
                y_out <= '0;
            end else if (hs) begin
                x_out <= x_last ? 11'd0 : x_out + 11'd1;
                if (x_last) y_out <= y_out + 11'd1;
            end
            // slot tag travels with the read so the returning pixel lands in the right element
            pv[0] <= state == S_ISSUE;
            pp[0] <= pad;
            pk[0] <= cnt[3:0];
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pp[i] <= pp[i-1];
                pk[i] <= pk[i-1];
            end
            if (pv[RD_LAT-1])
                win_data[pk[RD_LAT-1]*PIX_W +: PIX_W] <= pp[RD_LAT-1] ? '0 : mem_data;
        end
    end
endmodule
